dense_layer_engine: RTL and testbench

Fully-connected layer compute engine for the digit-recognition datapath. It is started by a one-cycle `go` pulse from the two-stage sequencer (one instance per stage, driven by Go1/Go2). It computes `N_OUT` neurons as ReLU(bias + Σ in·w), scaled and saturated, and writes them to an output activation buffer. It answers with a one-cycle `done` pulse (D1/D2), which the sequencer waits on.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/relu_sat.sv | 30 +++
 rtl/dense_layer_engine.sv | 157 +++++++++++++++
 tb/tb_dense_layer_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the dense-layer compute engines: FSM states,
// default widths and layer sizes, and the address-width helper.
package nn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MAC   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int N_IN_DEF   = 784;
   localparam int N_OUT_DEF  = 16;
   localparam int DATA_W_DEF = 8;
   localparam int W_W_DEF    = 8;
   localparam int B_W_DEF    = 16;
   localparam int ACC_W_DEF  = 28;
   localparam int OUT_W_DEF  = 8;
   localparam int SHIFT_DEF  = 7;

   // A single-entry memory still needs a 1-bit address port.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IN_AW_DEF = addr_w(N_IN_DEF);
   localparam int W_AW_DEF  = addr_w(N_IN_DEF * N_OUT_DEF);
   localparam int B_AW_DEF  = addr_w(N_OUT_DEF);

endpackage

// File: rtl/relu_sat.sv
// ReLU followed by arithmetic right shift and unsigned saturation of an
// accumulator to an output activation.
module relu_sat
   import nn_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [OUT_W-1:0] act
);

   localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   logic [ACC_W-1:0] shifted;

   // Negative sums clamp to zero; large positive sums clamp to full scale.
   always_comb begin
      shifted = acc >>> SHIFT;
      if (acc[ACC_W-1]) begin
         act = {OUT_W{1'b0}};
      end else if (shifted > MAX_V) begin
         act = MAX_V[OUT_W-1:0];
      end else begin
         act = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: streams inputs/weights from 1-cycle memories,
// accumulates bias + sum(in*w) per neuron and writes ReLU-saturated results.
module dense_layer_engine
   import nn_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int W_W    = W_W_DEF,
   parameter int B_W    = B_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int SHIFT  = SHIFT_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   localparam int IN_AW = addr_w(N_IN),
   localparam int W_AW  = addr_w(N_IN * N_OUT),
   localparam int B_AW  = addr_w(N_OUT)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   output logic              busy,
   output logic              done,
   output logic [IN_AW-1:0]  in_addr,
   input  logic [DATA_W-1:0] in_data,
   output logic [W_AW-1:0]   w_addr,
   input  logic [W_W-1:0]    w_data,
   output logic [B_AW-1:0]   b_addr,
   input  logic [B_W-1:0]    b_data,
   output logic              out_we,
   output logic [B_AW-1:0]   out_addr,
   output logic [OUT_W-1:0]  out_data
);

   localparam int PROD_W = DATA_W + W_W + 1;
   localparam logic [IN_AW-1:0] I_LAST = IN_AW'(N_IN - 1);
   localparam logic [B_AW-1:0]  J_LAST = B_AW'(N_OUT - 1);

   state_t state;
   state_t state_nxt;

   logic                     last_i;
   logic                     rd_valid;
   logic                     rd_first;
   logic signed [PROD_W-1:0] in_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_nxt;
   logic        [OUT_W-1:0]  act;

   // in_addr doubles as the input counter i, b_addr as the neuron counter j.
   assign last_i = (in_addr == I_LAST);

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (go) state_nxt = ST_MAC;
                   else    state_nxt = ST_IDLE;
         ST_MAC:   if (last_i) state_nxt = ST_DRAIN;
                   else        state_nxt = ST_MAC;
         ST_DRAIN: state_nxt = ST_WRITE;
         ST_WRITE: if (b_addr == J_LAST) state_nxt = ST_DONE;
                   else                  state_nxt = ST_MAC;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register, counters/addresses and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         out_we   <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
         in_addr  <= '0;
         w_addr   <= '0;
         b_addr   <= '0;
      end else begin
         state  <= state_nxt;
         busy   <= (state_nxt != ST_IDLE);
         done   <= (state_nxt == ST_DONE);
         out_we <= (state_nxt == ST_WRITE);
         case (state)
            ST_IDLE: begin
               if (go) begin
                  in_addr <= '0;
                  w_addr  <= '0;
                  b_addr  <= '0;
               end
            end
            ST_MAC: begin
               if (!last_i) begin
                  in_addr <= in_addr + IN_AW'(1);
                  w_addr  <= w_addr + W_AW'(1);
               end
            end
            ST_DRAIN: begin
               // Result is taken from the accumulator value being formed this cycle.
               out_addr <= b_addr;
               out_data <= act;
            end
            ST_WRITE: begin
               if (b_addr != J_LAST) begin
                  in_addr <= '0;
                  w_addr  <= w_addr + W_AW'(1);
                  b_addr  <= b_addr + B_AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Read-return tags: data arriving this cycle belongs to last cycle's MAC read.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_first <= 1'b0;
         acc      <= '0;
      end else begin
         rd_valid <= (state == ST_MAC);
         rd_first <= (state == ST_MAC) && (in_addr == '0);
         acc      <= acc_nxt;
      end
   end

   // Signed product and accumulate; bias is folded in with the first product.
   always_comb begin
      in_ext   = {{(W_W + 1){1'b0}}, in_data};
      w_ext    = {{(DATA_W + 1){w_data[W_W-1]}}, w_data};
      prod     = in_ext * w_ext;
      prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
      bias_ext = {{(ACC_W - B_W){b_data[B_W-1]}}, b_data};
      if (rd_valid) begin
         if (rd_first) acc_nxt = bias_ext + prod_ext;
         else          acc_nxt = acc + prod_ext;
      end else begin
         acc_nxt = acc;
      end
   end

   relu_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_relu_sat (
      .acc (acc_nxt),
      .act (act)
   );

endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed self-checking bench for dense_layer_engine (N_IN=4, N_OUT=2) with a
// SHIFT=11 companion instance and standalone relu_sat vectors.
module tb_dense_layer_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic               go;
   logic               busy, done, out_we;
   logic [1:0]         in_addr;
   logic [2:0]         w_addr;
   logic [0:0]         b_addr, out_addr;
   logic [7:0]         out_data;
   logic               busy2, done2, out_we2;
   logic [1:0]         in_addr2;
   logic [2:0]         w_addr2;
   logic [0:0]         b_addr2, out_addr2;
   logic [7:0]         out_data2;
   logic [7:0]         in_data;
   logic [7:0]         w_data;
   logic [15:0]        b_data;

   logic [7:0]         in_mem [4];
   logic [7:0]         w_mem  [8];
   logic [15:0]        b_mem  [2];

   logic signed [27:0] rs_acc;
   logic [7:0]         rs_act;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int overlap_cnt = 0;

   dense_layer_engine #(.N_IN(4), .N_OUT(2), .SHIFT(0)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .busy(busy), .done(done),
      .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data), .out_we(out_we), .out_addr(out_addr),
      .out_data(out_data)
   );

   dense_layer_engine #(.N_IN(4), .N_OUT(2), .SHIFT(11)) dut2 (
      .clk(clk), .reset_n(reset_n), .go(go), .busy(busy2), .done(done2),
      .in_addr(in_addr2), .in_data(in_data), .w_addr(w_addr2), .w_data(w_data),
      .b_addr(b_addr2), .b_data(b_data), .out_we(out_we2), .out_addr(out_addr2),
      .out_data(out_data2)
   );

   relu_sat #(.ACC_W(28), .SHIFT(11), .OUT_W(8)) u_rs (.acc(rs_acc), .act(rs_act));

   // Behavioural 1-cycle synchronous memories.
   always @(posedge clk) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
      b_data  <= b_mem[b_addr];
   end

   // Event monitor.
   always @(negedge clk) begin
      if (out_we) wr_cnt++;
      if (done) done_cnt++;
      if (out_we && done) overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [31:0] ins, input logic [63:0] ws, input logic [31:0] bs);
      for (int k = 0; k < 4; k++) in_mem[k] = ins[8*k +: 8];
      for (int k = 0; k < 8; k++) w_mem[k] = ws[8*k +: 8];
      for (int k = 0; k < 2; k++) b_mem[k] = bs[16*k +: 16];
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " busy"},     32'(busy),     32'd0);
      chk({tag, " done"},     32'(done),     32'd0);
      chk({tag, " out_we"},   32'(out_we),   32'd0);
      chk({tag, " out_addr"}, 32'(out_addr), 32'd0);
      chk({tag, " out_data"}, 32'(out_data), 32'd0);
      chk({tag, " in_addr"},  32'(in_addr),  32'd0);
      chk({tag, " w_addr"},   32'(w_addr),   32'd0);
      chk({tag, " b_addr"},   32'(b_addr),   32'd0);
   endtask

   // One full run; expectations for the SHIFT=0 and SHIFT=11 instances.
   task automatic run(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] s0, input logic [7:0] s1,
                      input bit repulse, input bit post);
      int n, p;
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      wr_cnt = 0;
      done_cnt = 0;
      for (int t = 1; t <= 13; t++) begin
         @(negedge clk);
         n = (t - 1) / 6;
         p = (t - 1) % 6;
         chk($sformatf("%s busy t=%0d", nm, t),  32'(busy),  32'd1);
         chk($sformatf("%s busy2 t=%0d", nm, t), 32'(busy2), 32'd1);
         chk($sformatf("%s done t=%0d", nm, t),  32'(done),  32'(t == 13));
         chk($sformatf("%s done2 t=%0d", nm, t), 32'(done2), 32'(t == 13));
         chk($sformatf("%s out_we t=%0d", nm, t), 32'(out_we), 32'(t < 13 && p == 5));
         chk($sformatf("%s out_we2 t=%0d", nm, t), 32'(out_we2), 32'(t < 13 && p == 5));
         if (t < 13 && p < 4) begin
            chk($sformatf("%s in_addr t=%0d", nm, t),  32'(in_addr),  32'(p));
            chk($sformatf("%s w_addr t=%0d", nm, t),   32'(w_addr),   32'(n * 4 + p));
            chk($sformatf("%s b_addr t=%0d", nm, t),   32'(b_addr),   32'(n));
            chk($sformatf("%s in_addr2 t=%0d", nm, t), 32'(in_addr2), 32'(p));
            chk($sformatf("%s w_addr2 t=%0d", nm, t),  32'(w_addr2),  32'(n * 4 + p));
            chk($sformatf("%s b_addr2 t=%0d", nm, t),  32'(b_addr2),  32'(n));
         end
         if (t < 13 && p == 5) begin
            chk($sformatf("%s out_addr t=%0d", nm, t),  32'(out_addr),  32'(n));
            chk($sformatf("%s out_addr2 t=%0d", nm, t), 32'(out_addr2), 32'(n));
            chk($sformatf("%s out_data n=%0d", nm, n),  32'(out_data),  32'((n == 0) ? e0 : e1));
            chk($sformatf("%s out_data2 n=%0d", nm, n), 32'(out_data2), 32'((n == 0) ? s0 : s1));
         end
         if (t == 13) chk($sformatf("%s write count", nm), 32'(wr_cnt), 32'd2);
         go = (repulse && (t == 3 || t == 13)) ? 1'b1 : 1'b0;
      end
      if (post) begin
         for (int t = 14; t <= 15; t++) begin
            @(negedge clk);
            go = 1'b0;
            chk($sformatf("%s idle busy t=%0d", nm, t), 32'(busy), 32'd0);
            chk($sformatf("%s idle done t=%0d", nm, t), 32'(done), 32'd0);
            chk($sformatf("%s idle we t=%0d", nm, t),   32'(out_we), 32'd0);
         end
         chk($sformatf("%s done count", nm), 32'(done_cnt), 32'd1);
         chk($sformatf("%s write total", nm), 32'(wr_cnt), 32'd2);
      end
   endtask

   initial begin
      logic signed [27:0] rs_in  [7];
      logic [7:0]         rs_exp [7];
      reset_n = 1'b0;
      go      = 1'b0;
      rs_acc  = 28'sd0;
      load(32'h0403_0201, 64'hFFFF_FFFF_0101_0101, 32'h0005_0000);

      // Standalone relu_sat with SHIFT=11.
      rs_in[0] = -28'sd1;      rs_exp[0] = 8'd0;
      rs_in[1] = 28'sd2047;    rs_exp[1] = 8'd0;
      rs_in[2] = 28'sd2048;    rs_exp[2] = 8'd1;
      rs_in[3] = 28'sd522239;  rs_exp[3] = 8'd254;
      rs_in[4] = 28'sd522240;  rs_exp[4] = 8'd255;
      rs_in[5] = 28'sd524288;  rs_exp[5] = 8'd255;
      rs_in[6] = 28'sd129540;  rs_exp[6] = 8'd63;
      for (int k = 0; k < 7; k++) begin
         rs_acc = rs_in[k];
         #1;
         chk($sformatf("relu_sat vec%0d", k), 32'(rs_act), 32'(rs_exp[k]));
      end

      // Reset held with go high.
      go = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_zero($sformatf("reset c%0d", k));
         chk($sformatf("reset busy2 c%0d", k), 32'(busy2), 32'd0);
      end
      chk("reset writes", 32'(wr_cnt), 32'd0);
      chk("reset dones", 32'(done_cnt), 32'd0);
      go = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // Basic run, then a second run started in the first IDLE cycle after done.
      run("basic", 8'd10, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      run("chained", 8'd10, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1);

      // Saturation with go re-pulsed during MAC and during DONE.
      load(32'hFFFF_FFFF, 64'h7F7F_7F7F_7F7F_7F7F, 32'h0000_0000);
      run("sat", 8'd255, 8'd255, 8'd63, 8'd63, 1'b1, 1'b1);

      // Reset during neuron 1 MAC.
      load(32'h0000_00FF, 64'h0000_0001_0505_0501, 32'hFFFF_0000);
      @(negedge clk);
      go = 1'b1;
      @(posedge clk);
      #1;
      go = 1'b0;
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      reset_n = 1'b1;
      wr_cnt = 0;
      done_cnt = 0;
      repeat (20) @(negedge clk);
      chk("midreset writes", 32'(wr_cnt), 32'd0);
      chk("midreset dones", 32'(done_cnt), 32'd0);

      run("after_reset", 8'd255, 8'd254, 8'd0, 8'd0, 1'b0, 1'b1);

      chk("done/out_we overlap", 32'(overlap_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
